// File: rtl/seg7_defs_pkg.sv
// Shared definitions for the 7-segment scan driver: FSM state codes, the
// active-low hex segment table and anode pattern helpers.
package seg7_defs;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low {g,f,e,d,c,b,a}, indexed by nibble value 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic is_one_cold(input logic [3:0] pattern);
    return (pattern == 4'b1110) || (pattern == 4'b1101) ||
           (pattern == 4'b1011) || (pattern == 4'b0111);
  endfunction

  function automatic logic [1:0] an_to_sel(input logic [3:0] pattern);
    logic [1:0] sel;
    case (pattern)
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      default: sel = 2'd0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex7seg
  import seg7_defs::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_drv.sv
// Downstream stage of the anode scanner: inserts dead-time blanking on each
// anode change, optional leading-zero suppression and illegal-pattern flagging.
module seg7_scan_drv
  import seg7_defs::*;
#(
  parameter int unsigned BLANK_CYC   = 16,
  parameter int unsigned LZ_SUPPRESS = 0,
  parameter int unsigned CNT_BITS    = 8
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [3:0]  AN_IN,
  input  logic [15:0] DATA,
  input  logic [3:0]  DP,
  input  logic        LOAD,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DPO,
  output logic        ERR
);

  localparam logic [CNT_BITS-1:0] CNT_RELOAD = CNT_BITS'(BLANK_CYC - 1);

  logic [3:0]          an_q, an_d;
  logic [1:0]          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [15:0]         data_q, data_d;
  logic [3:0]          dp_q, dp_d;
  logic [3:0]          an_out_q, an_out_d;
  logic [6:0]          seg_q, seg_d;
  logic                dpo_q, dpo_d;
  logic                err_q, err_d;

  logic       change;
  logic [1:0] sel;
  logic [3:0] digit;
  logic       lz_blank;
  logic [6:0] dec_seg;

  assign change = (AN_IN != an_q);

  // Any anode change overrides the current state; only BLANK advances on its own.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (change) begin
      if (AN_IN == AN_OFF) begin
        state_d = ST_IDLE;
      end else if (is_one_cold(AN_IN)) begin
        state_d = ST_BLANK;
        cnt_d   = CNT_RELOAD;
      end else begin
        state_d = ST_FAULT;
      end
    end else if (state_q == ST_BLANK) begin
      if (cnt_q == '0) begin
        state_d = ST_DRIVE;
      end else begin
        cnt_d = cnt_q - CNT_BITS'(1);
      end
    end
  end

  always_comb begin
    an_d   = AN_IN;
    data_d = LOAD ? DATA : data_q;
    dp_d   = LOAD ? DP : dp_q;
    sel    = an_to_sel(an_q);
  end

  // Digit mux and leading-zero test both look at the post-load shadow value.
  always_comb begin
    lz_blank = 1'b0;
    case (sel)
      2'd1: begin
        digit    = data_d[7:4];
        lz_blank = (data_d[15:4] == 12'h000);
      end
      2'd2: begin
        digit    = data_d[11:8];
        lz_blank = (data_d[15:8] == 8'h00);
      end
      2'd3: begin
        digit    = data_d[15:12];
        lz_blank = (data_d[15:12] == 4'h0);
      end
      default: digit = data_d[3:0];
    endcase
    if (LZ_SUPPRESS == 0) begin
      lz_blank = 1'b0;
    end
  end

  hex7seg u_hex7seg (
    .nibble (digit),
    .seg    (dec_seg)
  );

  always_comb begin
    an_out_d = AN_OFF;
    seg_d    = SEG_BLANK;
    dpo_d    = 1'b1;
    err_d    = err_q | (state_d == ST_FAULT);
    if (state_d == ST_DRIVE) begin
      an_out_d = an_q;
      seg_d    = lz_blank ? SEG_BLANK : dec_seg;
      dpo_d    = ~dp_d[sel];
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      an_q     <= AN_OFF;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      data_q   <= 16'h0000;
      dp_q     <= 4'b0000;
      an_out_q <= AN_OFF;
      seg_q    <= SEG_BLANK;
      dpo_q    <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      an_q     <= an_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      dp_q     <= dp_d;
      an_out_q <= an_out_d;
      seg_q    <= seg_d;
      dpo_q    <= dpo_d;
      err_q    <= err_d;
    end
  end

  assign AN  = an_out_q;
  assign SEG = seg_q;
  assign DPO = dpo_q;
  assign ERR = err_q;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Bench for seg7_scan_drv: two instances (plain/16-cycle blank and
// leading-zero suppression/1-cycle blank) driven from one stimulus stream.
module tb_seg7_scan_drv;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  an;
    logic [6:0]  seg_a;
    logic [6:0]  seg_b;
    logic        dpo;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg_a;
    logic [6:0] seg_b;
    logic       dpo;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[14];
  int   vec_count  = 0;
  int   miss_count = 0;

  logic        clk;
  logic        clr;
  logic [3:0]  an_in;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        load;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dpo_a, dpo_b;
  logic        err_a, err_b;

  seg7_scan_drv #(.BLANK_CYC(16), .LZ_SUPPRESS(0), .CNT_BITS(8)) u_dut_a (
    .CLK(clk), .CLR(clr), .AN_IN(an_in), .DATA(data), .DP(dp), .LOAD(load),
    .AN(an_a), .SEG(seg_a), .DPO(dpo_a), .ERR(err_a)
  );

  seg7_scan_drv #(.BLANK_CYC(1), .LZ_SUPPRESS(1), .CNT_BITS(8)) u_dut_b (
    .CLK(clk), .CLR(clr), .AN_IN(an_in), .DATA(data), .DP(dp), .LOAD(load),
    .AN(an_b), .SEG(seg_b), .DPO(dpo_b), .ERR(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Both instances dark; ERR as given.
  task automatic check_off(input string tag, input logic exp_err);
    check_output({tag, "_an_a"},  32'(an_a),  32'hF);
    check_output({tag, "_seg_a"}, 32'(seg_a), 32'h7F);
    check_output({tag, "_dpo_a"}, 32'(dpo_a), 32'h1);
    check_output({tag, "_err_a"}, 32'(err_a), 32'(exp_err));
    check_output({tag, "_an_b"},  32'(an_b),  32'hF);
    check_output({tag, "_seg_b"}, 32'(seg_b), 32'h7F);
    check_output({tag, "_dpo_b"}, 32'(dpo_b), 32'h1);
    check_output({tag, "_err_b"}, 32'(err_b), 32'(exp_err));
  endtask

  // Called at a negedge: drives one anode change, counts dark cycles on each
  // instance until it drives again, then checks against the queued result.
  task automatic apply_stimulus(input logic [3:0] an, input logic [15:0] d,
                                input logic [3:0] p, input logic ld, input exp_t e,
                                input int blank_a, input int blank_b);
    int   cnt_a  = 0;
    int   cnt_b  = 0;
    bit   done_a = 1'b0;
    bit   done_b = 1'b0;
    exp_t got;
    exp_q.push_back(e);
    an_in = an;
    data  = d;
    dp    = p;
    load  = ld;
    for (int c = 0; c < 300 && !(done_a && done_b); c++) begin
      @(negedge clk);
      load = 1'b0;
      if (!done_a) begin
        if (an_a == 4'b1111) cnt_a++;
        else done_a = 1'b1;
      end
      if (!done_b) begin
        if (an_b == 4'b1111) cnt_b++;
        else done_b = 1'b1;
      end
    end
    got = exp_q.pop_front();
    check_output("drive_reached_a", 32'(done_a), 32'h1);
    check_output("drive_reached_b", 32'(done_b), 32'h1);
    check_output("blank_cycles_a", 32'(cnt_a), 32'(blank_a));
    check_output("blank_cycles_b", 32'(cnt_b), 32'(blank_b));
    check_output("an_a",  32'(an_a),  32'(got.an));
    check_output("seg_a", 32'(seg_a), 32'(got.seg_a));
    check_output("dpo_a", 32'(dpo_a), 32'(got.dpo));
    check_output("err_a", 32'(err_a), 32'(got.err));
    check_output("an_b",  32'(an_b),  32'(got.an));
    check_output("seg_b", 32'(seg_b), 32'(got.seg_b));
    check_output("dpo_b", 32'(dpo_b), 32'(got.dpo));
    check_output("err_b", 32'(err_b), 32'(got.err));
  endtask

  initial begin
    int   cnt;
    exp_t e;

    // {data, dp, an, seg plain, seg with zero suppression, dpo}
    vecs[0]  = '{16'h1234, 4'b0001, 4'b1110, 7'b0011001, 7'b0011001, 1'b0};
    vecs[1]  = '{16'h1234, 4'b0001, 4'b1101, 7'b0110000, 7'b0110000, 1'b1};
    vecs[2]  = '{16'h0070, 4'b0000, 4'b0111, 7'b1000000, 7'b1111111, 1'b1};
    vecs[3]  = '{16'h0070, 4'b0000, 4'b1011, 7'b1000000, 7'b1111111, 1'b1};
    vecs[4]  = '{16'h0070, 4'b0000, 4'b1101, 7'b1111000, 7'b1111000, 1'b1};
    vecs[5]  = '{16'h0070, 4'b0000, 4'b1110, 7'b1000000, 7'b1000000, 1'b1};
    vecs[6]  = '{16'h00A0, 4'b0100, 4'b1011, 7'b1000000, 7'b1111111, 1'b0};
    vecs[7]  = '{16'hF00B, 4'b1000, 4'b0111, 7'b0001110, 7'b0001110, 1'b0};
    vecs[8]  = '{16'h9E8C, 4'b0000, 4'b1101, 7'b0000000, 7'b0000000, 1'b1};
    vecs[9]  = '{16'h5D6C, 4'b0000, 4'b1011, 7'b0100001, 7'b0100001, 1'b1};
    vecs[10] = '{16'h0005, 4'b1111, 4'b0111, 7'b1000000, 7'b1111111, 1'b0};
    vecs[11] = '{16'h0026, 4'b0000, 4'b1110, 7'b0000010, 7'b0000010, 1'b1};
    vecs[12] = '{16'h2BC9, 4'b0000, 4'b1011, 7'b0000011, 7'b0000011, 1'b1};
    vecs[13] = '{16'h0A1E, 4'b0010, 4'b1101, 7'b1111001, 7'b1111001, 1'b0};

    clr   = 1'b1;
    an_in = 4'b1111;
    data  = 16'h0000;
    dp    = 4'b0000;
    load  = 1'b0;
    repeat (3) @(negedge clk);
    check_off("reset", 1'b0);
    clr = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_off("idle_hold", 1'b0);
    end

    for (int i = 0; i < 14; i++) begin
      e = '{vecs[i].an, vecs[i].seg_a, vecs[i].seg_b, vecs[i].dpo, 1'b0};
      apply_stimulus(vecs[i].an, vecs[i].data, vecs[i].dp, 1'b1, e, 16, 1);
    end

    $display("[TB] mid-digit load");
    data = 16'h0A5E;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check_output("midload_an_a",  32'(an_a),  32'hD);
    check_output("midload_seg_a", 32'(seg_a), 32'(7'b0010010));
    check_output("midload_dpo_a", 32'(dpo_a), 32'h0);
    check_output("midload_an_b",  32'(an_b),  32'hD);
    check_output("midload_seg_b", 32'(seg_b), 32'(7'b0010010));

    $display("[TB] idle pattern and illegal pattern");
    an_in = 4'b1111;
    @(negedge clk);
    check_off("idle_pattern", 1'b0);
    @(negedge clk);
    check_off("idle_pattern_hold", 1'b0);
    an_in = 4'b1100;
    @(negedge clk);
    check_off("illegal", 1'b1);
    e = '{4'b1011, 7'b0001000, 7'b0001000, 1'b1, 1'b1};
    apply_stimulus(4'b1011, 16'h0A5E, 4'b0010, 1'b0, e, 16, 1);

    $display("[TB] blank restart");
    an_in = 4'b1101;
    repeat (5) @(negedge clk);
    check_output("restart_pre_an_a", 32'(an_a), 32'hF);
    an_in = 4'b1110;
    cnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (an_a != 4'b1111) break;
      cnt++;
    end
    check_output("restart_blank_a", 32'(cnt), 32'd16);
    check_output("restart_an_a",  32'(an_a),  32'hE);
    check_output("restart_seg_a", 32'(seg_a), 32'(7'b0000110));
    check_output("restart_dpo_a", 32'(dpo_a), 32'h1);
    check_output("restart_err_a", 32'(err_a), 32'h1);
    check_output("restart_an_b",  32'(an_b),  32'hE);
    check_output("restart_seg_b", 32'(seg_b), 32'(7'b0000110));

    $display("[TB] reset during blanking with load");
    an_in = 4'b0111;
    repeat (5) @(negedge clk);
    clr  = 1'b1;
    load = 1'b1;
    data = 16'hFFFF;
    dp   = 4'b1111;
    @(negedge clk);
    check_off("clr_mid_blank", 1'b0);
    clr  = 1'b0;
    load = 1'b0;
    e = '{4'b0111, 7'b1000000, 7'b1111111, 1'b1, 1'b0};
    apply_stimulus(4'b0111, 16'hFFFF, 4'b1111, 1'b0, e, 16, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/seg7_scan_drv.md
Name: seg7_scan_drv

Overview:
- Downstream stage of the running-zero anode scanner.
- Consumes the scanner's 4-bit one-cold anode vector and a latched 4-digit hex word.
- Drives the board's active-low anodes, 7 segments and decimal point.
- Inserts a dead-time blank on every anode change to prevent ghosting, suppresses leading zeros optionally, and flags illegal anode patterns.

Parameters:
- BLANK_CYC, 16: clock cycles of all-off blanking after each anode change; legal range 1..255.
- LZ_SUPPRESS, 0: 1 = blank leading zero digits (digit 0 is never blanked).
- CNT_BITS, 8: width of the blanking counter; must hold BLANK_CYC.

Ports:
- CLK  in  1  system clock.
- CLR  in  1  synchronous reset, active-high.
- AN_IN  in  4  one-cold anode pattern from the scanner. 1110 = digit0, 1101 = digit1, 1011 = digit2, 0111 = digit3.
- DATA  in  16  four hex digits; digit n = DATA[4n+3:4n].
- DP  in  4  decimal point per digit, 1 = lit.
- LOAD  in  1  one-cycle strobe that copies DATA/DP into the shadow registers.
- AN  out  4  anode drive, active-low.
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
- DPO  out  1  decimal point drive, active-low.
- ERR  out  1  sticky illegal-pattern flag.

Behaviour:
- Clocking and reset:
  - One clock; CLR is synchronous, active-high, and wins over all other inputs.
  - Reset values: AN=1111, SEG=1111111, DPO=1, ERR=0, shadow data=16'h0000, shadow DP=0000, an_q=1111, state=IDLE, counter=0.
- Input registration:
  - AN_IN is registered into an_q every cycle.
  - A change is detected when AN_IN != an_q.
- Shadow registers:
  - Loaded on the cycle LOAD=1 (not while CLR=1).
  - A new value is visible on SEG in the cycle after the load if the FSM is in DRIVE.
  - Segments change mid-digit without blanking; only anode changes blank.
- All outputs are registered. Nothing is combinational from an input to an output.
- FSM states:
  - IDLE: outputs off. On a change to a legal pattern, go to BLANK and load counter=BLANK_CYC-1. On an illegal pattern, go to FAULT.
  - BLANK: AN=1111, SEG=all off, DPO=1; counter decrements each cycle.
    - When counter==0, go to DRIVE with the anode equal to an_q.
    - Exactly BLANK_CYC cycles of AN=1111 precede DRIVE.
    - A new change during BLANK reloads the counter (restarts the dead time) and stays in BLANK.
  - DRIVE: AN=an_q, SEG=decode(selected digit), DPO=~DP[sel].
    - A change to a legal pattern goes to BLANK (AN=1111 on the next edge).
    - A change to an illegal pattern goes to FAULT.
  - FAULT: outputs off, ERR set. A change to a legal pattern goes to BLANK.
- Legal patterns: exactly one zero bit. 1111 is legal-idle: go to IDLE with outputs off, no ERR.
- ERR clears only on CLR.
- Latency: a legal AN_IN change at cycle t gives AN=1111 from t+1 and AN=new pattern from t+1+BLANK_CYC.
- Leading-zero suppression (LZ_SUPPRESS=1):
  - Digit 3 is blank if d3==0.
  - Digit 2 is blank if d3==0 and d2==0.
  - Digit 1 is blank if d3==0, d2==0 and d1==0.
  - A blanked digit forces SEG=1111111, but its DP is still honoured.
- Hex decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Simultaneous LOAD and anode change: the shadow value is taken; the next DRIVE shows the new data.

Decomposition:
- Shared package/include seg7_defs: FSM state encoding (IDLE, BLANK, DRIVE, FAULT), the 16-entry segment constant table, and the blank pattern 7'b1111111.
- One sub-module, hex7seg: a combinational nibble-to-segment decoder, instantiated once on the muxed digit.

Test Plan:
- Reset, then hold AN_IN=1111 -> AN=1111, SEG=1111111, DPO=1, ERR=0 indefinitely.
- LOAD DATA=16'h1234, DP=0001, then AN_IN=1110 at cycle t, BLANK_CYC=16 -> AN=1111 for t+1..t+16; at t+17 AN=1110, SEG=0011001 ("4"), DPO=0.
- Rotate AN_IN 1110→1101 mid-DRIVE -> exactly 16 cycles of AN=1111, then AN=1101, SEG=0110000 ("3").
- LZ_SUPPRESS=1, DATA=16'h0070, select digit3, then digit2, then digit1:
  - digit3 -> SEG=1111111
  - digit2 -> SEG=1111111
  - digit1 -> SEG=1111000 ("7")
- AN_IN=1100 (illegal) -> outputs off and ERR=1 on the next edge; return to 1011 -> BLANK then DRIVE, ERR stays 1 until CLR.
- CLR asserted mid-BLANK with LOAD simultaneously -> all outputs at reset values next edge, shadow=0000, LOAD ignored.
